flit_depacketizer: RTL and testbench

- Receive end of the NoC flit link.
- Consumes a stream of typed flits (HEAD/BODY/TAIL/SINGLE) over a valid/ready handshake and reassembles them into one packet: destination, source, payload words and length.
- Presents the packet on a parallel valid/ready output to the local core interface.
- Flags protocol violations and counts them.

---
 rtl/flit_depacketizer.sv | 125 ++++++++++++
 tb/tb_flit_depacketizer.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/flit_depacketizer.sv
// flit_depacketizer: receive end of the NoC flit link; reassembles HEAD/BODY/TAIL/SINGLE
// flits into a parallel packet and flags and counts protocol violations.
`default_nettype none

module flit_depacketizer #(
   parameter int FLIT_DATA_WIDTH = 32,
   parameter int FLIT_TYPE_WIDTH = 2,
   parameter int FLIT_WIDTH      = FLIT_DATA_WIDTH + FLIT_TYPE_WIDTH,
   parameter int MAX_PAYLOAD     = 4,
   parameter int LEN_WIDTH       = $clog2(MAX_PAYLOAD + 1)
) (
   input  logic                                   clk,
   input  logic                                   rst,
   input  logic [FLIT_WIDTH-1:0]                  flit_in,
   input  logic                                   flit_valid,
   output logic                                   flit_ready,
   output logic                                   pkt_valid,
   input  logic                                   pkt_ready,
   output logic [7:0]                             pkt_dest,
   output logic [7:0]                             pkt_src,
   output logic [LEN_WIDTH-1:0]                   pkt_len,
   output logic [MAX_PAYLOAD*FLIT_DATA_WIDTH-1:0] pkt_data,
   output logic                                   err,
   output logic [15:0]                            err_count
);

   localparam logic [FLIT_TYPE_WIDTH-1:0] TYPE_HEAD   = FLIT_TYPE_WIDTH'(0);
   localparam logic [FLIT_TYPE_WIDTH-1:0] TYPE_BODY   = FLIT_TYPE_WIDTH'(1);
   localparam logic [FLIT_TYPE_WIDTH-1:0] TYPE_TAIL   = FLIT_TYPE_WIDTH'(2);
   localparam logic [FLIT_TYPE_WIDTH-1:0] TYPE_SINGLE = FLIT_TYPE_WIDTH'(3);
   localparam logic [LEN_WIDTH-1:0]       COUNT_FULL  = LEN_WIDTH'(MAX_PAYLOAD);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      PAYLOAD = 2'd1,
      DELIVER = 2'd2
   } state_t;

   state_t                     state;
   logic [LEN_WIDTH-1:0]       count;
   logic [FLIT_TYPE_WIDTH-1:0] ftype;
   logic [FLIT_DATA_WIDTH-1:0] fdata;
   logic                       accept;
   logic                       err_set;

   assign ftype      = flit_in[FLIT_WIDTH-1 -: FLIT_TYPE_WIDTH];
   assign fdata      = flit_in[FLIT_DATA_WIDTH-1:0];
   assign flit_ready = (state != DELIVER) && !rst;
   assign accept     = flit_valid && flit_ready;

   // A stray payload flit outside a packet, or a header/overflow inside one, is a violation.
   always_comb begin
      err_set = 1'b0;
      if (accept) begin
         if (state == IDLE)
            err_set = (ftype == TYPE_BODY) || (ftype == TYPE_TAIL);
         else if (state == PAYLOAD)
            err_set = (ftype == TYPE_HEAD) || (ftype == TYPE_SINGLE) || (count == COUNT_FULL);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         count     <= '0;
         pkt_valid <= 1'b0;
         pkt_dest  <= '0;
         pkt_src   <= '0;
         pkt_len   <= '0;
         pkt_data  <= '0;
         err       <= 1'b0;
         err_count <= '0;
      end else begin
         err <= err_set;
         if (err_set && (err_count != 16'hFFFF))
            err_count <= err_count + 16'd1;

         case (state)
            IDLE, PAYLOAD: begin
               if (accept) begin
                  if ((ftype == TYPE_HEAD) || (ftype == TYPE_SINGLE)) begin
                     // Any header restarts assembly; an unfinished packet is simply abandoned.
                     pkt_dest <= fdata[FLIT_DATA_WIDTH-1 -: 8];
                     pkt_src  <= fdata[FLIT_DATA_WIDTH-9 -: 8];
                     pkt_len  <= '0;
                     pkt_data <= '0;
                     count    <= '0;
                     if (ftype == TYPE_SINGLE) begin
                        state     <= DELIVER;
                        pkt_valid <= 1'b1;
                     end else begin
                        state <= PAYLOAD;
                     end
                  end else if (state == PAYLOAD) begin
                     if (count == COUNT_FULL) begin
                        state <= IDLE;
                     end else begin
                        for (int i = 0; i < MAX_PAYLOAD; i++) begin
                           if (count == LEN_WIDTH'(i))
                              pkt_data[i*FLIT_DATA_WIDTH +: FLIT_DATA_WIDTH] <= fdata;
                        end
                        count <= count + 1'b1;
                        if (ftype == TYPE_TAIL) begin
                           pkt_len   <= count + 1'b1;
                           state     <= DELIVER;
                           pkt_valid <= 1'b1;
                        end
                     end
                  end
               end
            end
            DELIVER: begin
               if (pkt_ready) begin
                  pkt_valid <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_flit_depacketizer.sv
// tb_flit_depacketizer: directed and randomized flit sequences checked against a
// queue-based packet model using immediate assertions.
`default_nettype none
`timescale 1ns/1ps

module tb_flit_depacketizer;

   localparam int DW   = 32;
   localparam int MAXP = 4;
   localparam int LW   = $clog2(MAXP + 1);
   localparam logic [1:0] T_HEAD   = 2'b00;
   localparam logic [1:0] T_BODY   = 2'b01;
   localparam logic [1:0] T_TAIL   = 2'b10;
   localparam logic [1:0] T_SINGLE = 2'b11;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic [DW+1:0]     flit_in = '0;
   logic              flit_valid = 1'b0;
   logic              flit_ready;
   logic              pkt_valid;
   logic              pkt_ready = 1'b0;
   logic [7:0]        pkt_dest;
   logic [7:0]        pkt_src;
   logic [LW-1:0]     pkt_len;
   logic [MAXP*DW-1:0] pkt_data;
   logic              err;
   logic [15:0]       err_count;

   always #5 clk = ~clk;

   flit_depacketizer dut (
      .clk        (clk),
      .rst        (rst),
      .flit_in    (flit_in),
      .flit_valid (flit_valid),
      .flit_ready (flit_ready),
      .pkt_valid  (pkt_valid),
      .pkt_ready  (pkt_ready),
      .pkt_dest   (pkt_dest),
      .pkt_src    (pkt_src),
      .pkt_len    (pkt_len),
      .pkt_data   (pkt_data),
      .err        (err),
      .err_count  (err_count)
   );

   int total = 0;
   int bad   = 0;

   // Reference model: packet-level view of the link.
   bit           m_in_pkt = 1'b0;
   logic [7:0]   m_dest = '0;
   logic [7:0]   m_src  = '0;
   logic [31:0]  m_words[$];
   int           m_errs = 0;
   bit           exp_err = 1'b0;
   bit           exp_pkt = 1'b0;
   logic [7:0]   exp_dest = '0;
   logic [7:0]   exp_src  = '0;
   int           exp_len  = 0;
   logic [127:0] exp_data = '0;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
      total++;
      assert (obs === expv) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic model_deliver();
      exp_pkt  = 1'b1;
      exp_dest = m_dest;
      exp_src  = m_src;
      exp_len  = m_words.size();
      exp_data = '0;
      foreach (m_words[i]) exp_data[i*32 +: 32] = m_words[i];
      m_words.delete();
   endtask

   task automatic model_accept(input logic [1:0] t, input logic [31:0] d);
      exp_err = 1'b0;
      exp_pkt = 1'b0;
      if (t == T_HEAD || t == T_SINGLE) begin
         if (m_in_pkt) exp_err = 1'b1;
         m_dest = d[31:24];
         m_src  = d[23:16];
         m_words.delete();
         m_in_pkt = (t == T_HEAD);
         if (t == T_SINGLE) model_deliver();
      end else if (!m_in_pkt) begin
         exp_err = 1'b1;
      end else if (m_words.size() == MAXP) begin
         exp_err  = 1'b1;
         m_in_pkt = 1'b0;
         m_words.delete();
      end else begin
         m_words.push_back(d);
         if (t == T_TAIL) begin
            m_in_pkt = 1'b0;
            model_deliver();
         end
      end
      if (exp_err && m_errs < 65535) m_errs++;
   endtask

   // Offer one flit after a random idle gap; called and returns at a falling edge.
   task automatic send(input logic [1:0] t, input logic [31:0] d, input int max_gap);
      int waited;
      flit_valid = 1'b0;
      repeat ($urandom_range(0, max_gap)) @(negedge clk);
      flit_in    = {t, d};
      flit_valid = 1'b1;
      waited     = 0;
      while (flit_ready !== 1'b1 && waited < 20) begin
         @(negedge clk);
         waited++;
      end
      if (waited >= 20) begin
         chk("ready_timeout", 128'(1'b0), 128'(1'b1));
         flit_valid = 1'b0;
         return;
      end
      @(posedge clk);
      model_accept(t, d);
      @(negedge clk);
      flit_valid = 1'b0;
      chk("err", 128'(err), 128'(exp_err));
      chk("err_count", 128'(err_count), 128'(m_errs));
      chk("pkt_valid_after_flit", 128'(pkt_valid), 128'(exp_pkt));
   endtask

   // Hold the packet for 'hold' extra cycles while a flit is offered, then handshake.
   task automatic deliver(input int hold);
      if (!exp_pkt) return;
      pkt_ready  = 1'b0;
      flit_in    = {T_HEAD, 32'hDEAD_0000};
      flit_valid = 1'b1;
      for (int i = 0; i <= hold; i++) begin
         chk("pkt_valid", 128'(pkt_valid), 128'(1'b1));
         chk("pkt_dest", 128'(pkt_dest), 128'(exp_dest));
         chk("pkt_src", 128'(pkt_src), 128'(exp_src));
         chk("pkt_len", 128'(pkt_len), 128'(exp_len));
         chk("pkt_data", 128'(pkt_data), exp_data);
         chk("flit_ready_in_deliver", 128'(flit_ready), 128'(1'b0));
         if (i < hold) @(negedge clk);
      end
      flit_valid = 1'b0;
      pkt_ready  = 1'b1;
      @(posedge clk);
      @(negedge clk);
      pkt_ready = 1'b0;
      exp_pkt   = 1'b0;
      chk("pkt_valid_cleared", 128'(pkt_valid), 128'(1'b0));
      chk("flit_ready_restored", 128'(flit_ready), 128'(1'b1));
   endtask

   task automatic do_reset();
      rst        = 1'b1;
      flit_valid = 1'b0;
      pkt_ready  = 1'b0;
      @(posedge clk);
      @(negedge clk);
      chk("rst_pkt_valid", 128'(pkt_valid), 128'(1'b0));
      chk("rst_pkt_dest", 128'(pkt_dest), 128'(8'h00));
      chk("rst_pkt_src", 128'(pkt_src), 128'(8'h00));
      chk("rst_pkt_len", 128'(pkt_len), 128'(0));
      chk("rst_pkt_data", 128'(pkt_data), 128'(0));
      chk("rst_err", 128'(err), 128'(1'b0));
      chk("rst_err_count", 128'(err_count), 128'(0));
      chk("rst_flit_ready_low", 128'(flit_ready), 128'(1'b0));
      rst = 1'b0;
      #1;
      chk("flit_ready_after_rst", 128'(flit_ready), 128'(1'b1));
      m_in_pkt = 1'b0;
      m_words.delete();
      m_errs  = 0;
      exp_err = 1'b0;
      exp_pkt = 1'b0;
   endtask

   function automatic logic [31:0] hdr(input logic [7:0] dest, input logic [7:0] src);
      logic [15:0] pad;
      pad = 16'($urandom);
      return {dest, src, pad};
   endfunction

   initial begin
      int n;
      @(negedge clk);
      do_reset();

      // Nominal three-word packet.
      send(T_HEAD, hdr(8'h12, 8'h34), 0);
      send(T_BODY, 32'hA, 0);
      send(T_BODY, 32'hB, 0);
      send(T_TAIL, 32'hC, 0);
      deliver(0);

      // Header-only packet held under backpressure with a flit waiting.
      send(T_SINGLE, hdr(8'h01, 8'h02), 0);
      deliver(5);

      // Overflow discards the packet; a following SINGLE is delivered.
      send(T_HEAD, hdr(8'h21, 8'h43), 0);
      repeat (4) send(T_BODY, $urandom, 0);
      send(T_TAIL, $urandom, 0);
      deliver(0);
      send(T_SINGLE, hdr(8'h77, 8'h88), 1);
      deliver(1);

      // Stray BODY in idle, then a header restart mid-packet.
      do_reset();
      send(T_BODY, 32'h5, 0);
      send(T_HEAD, hdr(8'h55, 8'h10), 0);
      send(T_BODY, 32'h1, 0);
      send(T_HEAD, hdr(8'h66, 8'h20), 0);
      send(T_TAIL, 32'h9, 0);
      deliver(0);

      // Full-size packet with random valid gaps.
      send(T_HEAD, hdr(8'h9A, 8'hBC), 3);
      repeat (3) send(T_BODY, $urandom, 3);
      send(T_TAIL, $urandom, 3);
      deliver(2);

      // Reset mid-packet, then a one-word packet with no stale words.
      send(T_HEAD, hdr(8'hE1, 8'hE2), 0);
      send(T_BODY, 32'hFFFF_FFFF, 0);
      send(T_BODY, 32'hEEEE_EEEE, 0);
      do_reset();
      send(T_HEAD, hdr(8'h3C, 8'h4D), 0);
      send(T_TAIL, 32'h1234_5678, 0);
      deliver(0);

      // Randomized packets, including header-only, overflow and stray flits.
      for (int p = 0; p < 25; p++) begin
         n = $urandom_range(0, MAXP + 1);
         if ($urandom_range(0, 4) == 0) send(T_BODY, $urandom, 1);
         if (n == 0) begin
            send(T_SINGLE, $urandom, 2);
         end else begin
            send(T_HEAD, $urandom, 2);
            for (int k = 0; k < n - 1; k++) send(T_BODY, $urandom, 2);
            send(T_TAIL, $urandom, 2);
         end
         deliver($urandom_range(0, 2));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "simulation time limit reached");
   end

endmodule

`default_nettype wire
